// File: rtl/uart_frame_rx.sv
// Frame parser behind the uart RX FIFO. It extracts SOF / LEN / payload / CHK frames, streams the
// payload out on valid/ready and ends every started frame with one ok or one error pulse.
//
// state     | meaning
// S_IDLE    | hunting for SOF, any other byte is dropped
// S_LEN     | waiting for the length byte
// S_PAYLOAD | forwarding payload, cnt = payload bytes still to come
// S_CHK     | waiting for the checksum byte

module uart_frame_rx #(
   parameter int                D_BITS      = 8,
   parameter logic [D_BITS-1:0] SOF_BYTE    = 'hA5,
   parameter int                MAX_LEN     = 32,
   parameter int                TIMEOUT_CYC = 100000
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              rx_empty_i,
   input  logic [D_BITS-1:0] rx_byte_i,
   output logic              rx_rd_ena_o,
   output logic [D_BITS-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              sof_o,
   output logic              frame_ok_o,
   output logic              frame_err_o,
   output logic [1:0]        err_code_o,
   output logic [D_BITS-1:0] len_o
);

   localparam int                TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]     TMO_LOAD  = TW'(TIMEOUT_CYC);
   localparam logic [D_BITS-1:0] MAX_LEN_B = D_BITS'(MAX_LEN);
   localparam logic [1:0]        ERR_CHK   = 2'b01;
   localparam logic [1:0]        ERR_LEN   = 2'b10;
   localparam logic [1:0]        ERR_TMO   = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK} state_t;

   state_t            state, state_nxt;
   logic              rd_pend;
   logic              stall;
   logic              tmo_count;
   logic              timeout;
   logic [TW-1:0]     timer;
   logic [D_BITS-1:0] sum;
   logic [D_BITS-1:0] sum_add;
   logic [D_BITS-1:0] cnt;
   logic              ok_nxt;
   logic              err_nxt;
   logic [1:0]        code_nxt;

   // A forwarded payload byte blocks further payload pops until the consumer takes it
   assign stall       = (state == S_PAYLOAD) && valid_o;
   assign rx_rd_ena_o = reset_i && !rx_empty_i && !rd_pend && !stall;
   assign tmo_count   = (state != S_IDLE) && !rd_pend && !stall && !rx_rd_ena_o;
   assign timeout     = tmo_count && (timer == TW'(1));
   assign sum_add     = sum + rx_byte_i;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;
      code_nxt  = err_code_o;
      case (state)
         S_IDLE: begin
            if (rd_pend && rx_byte_i == SOF_BYTE) state_nxt = S_LEN;
         end
         S_LEN: begin
            if (rd_pend) begin
               if (rx_byte_i > MAX_LEN_B) begin
                  err_nxt   = 1'b1;
                  code_nxt  = ERR_LEN;
                  state_nxt = S_IDLE;
               end else if (rx_byte_i == '0) begin
                  state_nxt = S_CHK;
               end else begin
                  state_nxt = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rd_pend && cnt == D_BITS'(1)) state_nxt = S_CHK;
         end
         S_CHK: begin
            if (rd_pend) begin
               if (sum_add == '0) begin
                  ok_nxt = 1'b1;
               end else begin
                  err_nxt  = 1'b1;
                  code_nxt = ERR_CHK;
               end
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (timeout) begin
         err_nxt   = 1'b1;
         code_nxt  = ERR_TMO;
         state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rd_pend     <= 1'b0;
         timer       <= '0;
         sum         <= '0;
         cnt         <= '0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         sof_o       <= 1'b0;
         frame_ok_o  <= 1'b0;
         frame_err_o <= 1'b0;
         err_code_o  <= 2'b00;
         len_o       <= '0;
      end else begin
         rd_pend     <= rx_rd_ena_o;
         frame_ok_o  <= ok_nxt;
         frame_err_o <= err_nxt;
         err_code_o  <= code_nxt;
         if (rd_pend)        timer <= TMO_LOAD;
         else if (tmo_count) timer <= timer - TW'(1);
         if (rd_pend && state == S_LEN) begin
            sum   <= rx_byte_i;
            len_o <= rx_byte_i;
            cnt   <= rx_byte_i;
         end else if (rd_pend && state == S_PAYLOAD) begin
            sum <= sum_add;
            cnt <= cnt - D_BITS'(1);
         end
         // First payload byte is the one arriving while cnt still equals LEN
         if (rd_pend && state == S_PAYLOAD) begin
            data_o  <= rx_byte_i;
            valid_o <= 1'b1;
            sof_o   <= (cnt == len_o);
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a table of whole frames plus hand-written sequences for
// timeout, consumer stall, back-to-back frames and asynchronous reset.

module tb_uart_frame_rx;

   localparam int MAX_LEN = 32;
   localparam int TMO     = 40;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       rx_empty_i;
   logic [7:0] rx_byte_i;
   logic       rx_rd_ena_o;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       sof_o;
   logic       frame_ok_o;
   logic       frame_err_o;
   logic [1:0] err_code_o;
   logic [7:0] len_o;

   uart_frame_rx #(
      .D_BITS(8), .SOF_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .rx_empty_i(rx_empty_i), .rx_byte_i(rx_byte_i),
      .rx_rd_ena_o(rx_rd_ena_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .sof_o(sof_o), .frame_ok_o(frame_ok_o), .frame_err_o(frame_err_o),
      .err_code_o(err_code_o), .len_o(len_o)
   );

   always #5 clk_i = ~clk_i;

   // RX FIFO model: read data appears the cycle after the pop
   logic [7:0] fifo_mem [0:1023];
   int pushed = 0;
   int popped = 0;
   assign rx_empty_i = (pushed == popped);

   always @(posedge clk_i) begin
      if (rx_rd_ena_o && pushed != popped) begin
         rx_byte_i <= fifo_mem[popped];
         popped    <= popped + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      fifo_mem[pushed] = b;
      pushed = pushed + 1;
   endtask

   // Output monitor
   int         mon_n = 0, mon_ok = 0, mon_err = 0, mon_pops = 0, mon_both = 0;
   logic [7:0] mon_data [0:255];
   logic       mon_sof  [0:255];

   always @(negedge clk_i) begin
      if (valid_o && ready_i && mon_n < 256) begin
         mon_data[mon_n] <= data_o;
         mon_sof[mon_n]  <= sof_o;
         mon_n           <= mon_n + 1;
      end
      if (frame_ok_o)                mon_ok   <= mon_ok + 1;
      if (frame_err_o)               mon_err  <= mon_err + 1;
      if (frame_ok_o && frame_err_o) mon_both <= mon_both + 1;
      if (rx_rd_ena_o)               mon_pops <= mon_pops + 1;
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot = n_tot + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic [7:0] b [0:39];
      int         n;
      int         pl_off;
      int         npl;
      int         ok;
      int         err;
      logic [1:0] code;
      logic [7:0] len;
   } vec_t;

   vec_t vecs [0:7];

   function automatic vec_t mk(input int n, input logic [63:0] raw, input int pl_off,
                               input int npl, input int ok, input int err,
                               input logic [1:0] code, input logic [7:0] len);
      vec_t v;
      for (int i = 0; i < 40; i++) v.b[i] = 8'h00;
      for (int i = 0; i < 8; i++) v.b[i] = raw[63-8*i -: 8];
      v.n = n; v.pl_off = pl_off; v.npl = npl; v.ok = ok; v.err = err;
      v.code = code; v.len = len;
      return v;
   endfunction

   task automatic run_vec(input int idx);
      vec_t v;
      int   n0, ok0, err0, pop0;
      bit   done;
      v = vecs[idx];
      @(posedge clk_i); #1;
      ready_i = 1'b1;
      n0 = mon_n; ok0 = mon_ok; err0 = mon_err; pop0 = mon_pops;
      for (int i = 0; i < v.n; i++) push(v.b[i]);
      done = 1'b0;
      for (int c = 0; c < 600 && !done; c++) begin
         @(negedge clk_i);
         if ((mon_ok - ok0) + (mon_err - err0) >= v.ok + v.err && pushed == popped) done = 1'b1;
      end
      repeat (6) @(negedge clk_i);
      check($sformatf("v%0d done", idx), done, 1);
      check($sformatf("v%0d pops", idx), mon_pops - pop0, v.n);
      check($sformatf("v%0d ok", idx), mon_ok - ok0, v.ok);
      check($sformatf("v%0d err", idx), mon_err - err0, v.err);
      check($sformatf("v%0d len", idx), len_o, v.len);
      check($sformatf("v%0d nbytes", idx), mon_n - n0, v.npl);
      check($sformatf("v%0d valid idle", idx), valid_o, 0);
      if (v.err > 0) check($sformatf("v%0d code", idx), err_code_o, v.code);
      for (int i = 0; i < v.npl; i++) begin
         check($sformatf("v%0d data%0d", idx, i), mon_data[n0+i], v.b[v.pl_off+i]);
         check($sformatf("v%0d sof%0d", idx, i), mon_sof[n0+i], (i == 0));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int         c, ok0, err0, pop0, n0, stable;
      bit         got;
      logic [7:0] e3 [0:2];

      vecs[0] = mk(6, 64'hA5_03_11_22_33_97_00_00, 2, 3, 1, 0, 2'b00, 8'h03);
      vecs[1] = mk(6, 64'hA5_03_11_22_33_98_00_00, 2, 3, 0, 1, 2'b01, 8'h03);
      vecs[2] = mk(6, 64'h00_FF_5A_A5_00_00_00_00, 0, 0, 1, 0, 2'b00, 8'h00);
      vecs[3] = mk(2, 64'hA5_21_00_00_00_00_00_00, 0, 0, 0, 1, 2'b10, 8'h21);
      vecs[4] = mk(4, 64'hA5_01_7E_81_00_00_00_00, 2, 1, 1, 0, 2'b00, 8'h01);
      vecs[5] = mk(5, 64'hA5_02_A5_5A_FF_00_00_00, 2, 2, 1, 0, 2'b00, 8'h02);
      vecs[6] = mk(3, 64'hA5_00_01_00_00_00_00_00, 0, 0, 0, 1, 2'b01, 8'h00);
      vecs[7] = mk(35, 64'hA5_20_00_00_00_00_00_00, 2, 32, 1, 0, 2'b00, 8'h20);
      for (int i = 1; i <= 32; i++) vecs[7].b[1+i] = 8'(i);
      vecs[7].b[34] = 8'hD0;

      reset_i = 1'b0;
      ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("reset outputs", {rx_rd_ena_o, data_o, valid_o, sof_o, frame_ok_o, frame_err_o,
                              err_code_o, len_o}, 0);
      @(posedge clk_i); #1;
      reset_i = 1'b1;

      for (int k = 0; k < 8; k++) run_vec(k);

      // Timeout: frame stops after the first payload byte
      @(posedge clk_i); #1;
      pop0 = mon_pops;
      push(8'hA5); push(8'h02); push(8'h10);
      c = 0;
      while (popped != pushed && c < 100) begin @(negedge clk_i); c++; end
      c = 0; got = 1'b0;
      while (c < 200 && !got) begin
         @(negedge clk_i); c++;
         if (frame_err_o) got = 1'b1;
      end
      check("tmo seen", got, 1);
      check("tmo latency", (c >= 40 && c <= 44), 1);
      check("tmo code", err_code_o, 2'b11);
      @(negedge clk_i);
      check("tmo pulse width", frame_err_o, 0);
      repeat (3) @(negedge clk_i);
      check("tmo pops", mon_pops - pop0, 3);

      // Consumer stall longer than the timeout mid-payload
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      n0 = mon_n; ok0 = mon_ok; err0 = mon_err;
      push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
      c = 0; got = 1'b0;
      while (c < 100 && !got) begin @(negedge clk_i); c++; if (valid_o) got = 1'b1; end
      check("stall valid seen", got, 1);
      pop0 = mon_pops; stable = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (valid_o === 1'b1 && data_o === 8'h11 && sof_o === 1'b1 &&
             frame_err_o === 1'b0 && rx_rd_ena_o === 1'b0) stable++;
      end
      check("stall stable cycles", stable, 50);
      check("stall pops", mon_pops - pop0, 0);
      @(posedge clk_i); #1;
      ready_i = 1'b1;
      c = 0;
      while (c < 100 && mon_ok == ok0) begin @(negedge clk_i); c++; end
      repeat (4) @(negedge clk_i);
      check("stall ok", mon_ok - ok0, 1);
      check("stall err", mon_err - err0, 0);
      check("stall nbytes", mon_n - n0, 3);
      e3[0] = 8'h11; e3[1] = 8'h22; e3[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall data%0d", i), mon_data[n0+i], e3[i]);
         check($sformatf("stall sof%0d", i), mon_sof[n0+i], (i == 0));
      end

      // Next frames complete while the last payload byte still waits on ready_i
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      n0 = mon_n; ok0 = mon_ok; pop0 = mon_pops;
      push(8'hA5); push(8'h01); push(8'h7E); push(8'h81); push(8'hA5); push(8'h00); push(8'h00);
      c = 0;
      while (c < 200 && mon_ok - ok0 < 2) begin @(negedge clk_i); c++; end
      repeat (2) @(negedge clk_i);
      check("b2b ok", mon_ok - ok0, 2);
      check("b2b held", {valid_o, sof_o, data_o}, {1'b1, 1'b1, 8'h7E});
      check("b2b pops", mon_pops - pop0, 7);
      @(posedge clk_i); #1;
      ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("b2b nbytes", mon_n - n0, 1);
      check("b2b data", mon_data[n0], 8'h7E);

      // Asynchronous reset mid-frame, then recovery
      @(posedge clk_i); #1;
      ready_i = 1'b0;
      push(8'hA5); push(8'h03); push(8'h11);
      c = 0; got = 1'b0;
      while (c < 100 && !got) begin @(negedge clk_i); c++; if (valid_o) got = 1'b1; end
      check("rst pre valid", {got, data_o, len_o}, {1'b1, 8'h11, 8'h03});
      #2;
      reset_i = 1'b0;
      #1;
      check("rst async outputs", {rx_rd_ena_o, data_o, valid_o, sof_o, frame_ok_o, frame_err_o,
                                  err_code_o, len_o}, 0);
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      ready_i = 1'b1;
      run_vec(4);

      check("never ok and err together", mon_both, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
